// File: rtl/bias_ram_arb_pkg.sv
// Shared constants and types for the bias RAM arbiter slice.
// Holds default bus widths, the RAM read latency, the wait-counter width,
// the arbitration op encoding and a saturating-increment helper.
package bias_ram_arb_pkg;

  localparam int BIAS_ADDR_W_DEF = 8;
  localparam int BIAS_DATA_W_DEF = 32;
  // Cycles from a RAM read being driven to i_ram_rdata being valid.
  localparam int BIAS_RAM_RD_LAT = 1;
  localparam int BIAS_WAIT_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } ram_op_t;

  function automatic logic [BIAS_WAIT_CNT_W-1:0] sat_inc(input logic [BIAS_WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bias_wbuf.sv
// Write buffer for DMA bias writes with a youngest-match address lookup.
// Latency: push visible from the next cycle; lookup is combinational.
// Backpressure: o_full is registered; caller must not push when full or pop when empty.
// Ports: i_clk/i_rst, push (addr/data), pop, head addr/data, o_empty/o_full,
//        lookup address in, hit flag and data out.
module bias_wbuf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_push_addr,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [ADDR_WIDTH-1:0] o_head_addr,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_empty,
  output logic                  o_full,
  input  logic [ADDR_WIDTH-1:0] i_lk_addr,
  output logic                  o_lk_hit,
  output logic [DATA_WIDTH-1:0] o_lk_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q, count_nxt;

  assign count_nxt = count_q + CNT_W'(i_push) - CNT_W'(i_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      // Flags come from the next count so they are plain flops, not decode.
      o_empty <= (count_nxt == '0);
      o_full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      addr_mem[wr_ptr] <= i_push_addr;
      data_mem[wr_ptr] <= i_push_data;
    end
  end

  assign o_head_addr = addr_mem[rd_ptr];
  assign o_head_data = data_mem[rd_ptr];

  // Walk entries oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    o_lk_hit  = 1'b0;
    o_lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_mem[idx] == i_lk_addr)) begin
        o_lk_hit  = 1'b1;
        o_lk_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/bias_ram_arb.sv
// Arbiter for the single-port bias RAM: compute reads win, DMA writes drain into idle cycles.
// Latency: RAM op registered one cycle after decision; read data returned exactly 2 cycles after request.
// Backpressure: reads never stall; DMA writes use o_wr_rdy (registered not-full of the write buffer).
// Ports: i_clk/i_rst, DMA write (vld/rdy/addr/data), compute read (en/addr) and return (vld/data),
//        RAM side (en/we/addr/wdata/rdata), wait statistic (clr/cnt), o_idle.
module bias_ram_arb
  import bias_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = BIAS_ADDR_W_DEF,
  parameter int DATA_WIDTH = BIAS_DATA_W_DEF,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_vld,
  output logic                       o_wr_rdy,
  input  logic [ADDR_WIDTH-1:0]      i_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic                       i_rd_en,
  input  logic [ADDR_WIDTH-1:0]      i_rd_addr,
  output logic                       o_rd_vld,
  output logic [DATA_WIDTH-1:0]      o_rd_data,
  output logic                       o_ram_en,
  output logic                       o_ram_we,
  output logic [ADDR_WIDTH-1:0]      o_ram_addr,
  output logic [DATA_WIDTH-1:0]      o_ram_wdata,
  input  logic [DATA_WIDTH-1:0]      i_ram_rdata,
  input  logic                       i_clr_stat,
  output logic [BIAS_WAIT_CNT_W-1:0] o_wait_cnt,
  output logic                       o_idle
);

  // One stage for the registered RAM command plus the RAM's own latency.
  localparam int RET_STAGES = 1 + BIAS_RAM_RD_LAT;

  logic                  buf_empty, buf_full;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  lk_hit;
  logic [DATA_WIDTH-1:0] lk_data;
  logic                  push, pop;
  ram_op_t               op;
  logic                  en_d1;
  logic [RET_STAGES-1:0] vld_sr, hit_sr;
  logic [DATA_WIDTH-1:0] fwd_sr [RET_STAGES];

  assign o_wr_rdy = ~buf_full;
  assign push     = i_wr_vld & o_wr_rdy;

  always_comb begin
    op = OP_IDLE;
    if (i_rd_en)         op = OP_READ;
    else if (!buf_empty) op = OP_WRITE;
  end

  assign pop = (op == OP_WRITE);

  // A write pushed this cycle is not yet in the lookup, so it stays ordered after a same-cycle read.
  bias_wbuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (WBUF_DEPTH)
  ) u_wbuf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_addr (i_wr_addr),
    .i_push_data (i_wr_data),
    .i_pop       (pop),
    .o_head_addr (head_addr),
    .o_head_data (head_data),
    .o_empty     (buf_empty),
    .o_full      (buf_full),
    .i_lk_addr   (i_rd_addr),
    .o_lk_hit    (lk_hit),
    .o_lk_data   (lk_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      en_d1       <= 1'b0;
      o_wait_cnt  <= '0;
      vld_sr      <= '0;
      hit_sr      <= '0;
    end else begin
      o_ram_en <= (op != OP_IDLE);
      o_ram_we <= (op == OP_WRITE);
      // Address/data hold on idle cycles to avoid needless RAM pin toggling.
      case (op)
        OP_READ:  o_ram_addr <= i_rd_addr;
        OP_WRITE: begin
          o_ram_addr  <= head_addr;
          o_ram_wdata <= head_data;
        end
        default: ;
      endcase
      en_d1 <= o_ram_en;
      if (i_clr_stat)
        o_wait_cnt <= '0;
      else if (i_rd_en && !buf_empty)
        o_wait_cnt <= sat_inc(o_wait_cnt);
      vld_sr <= {vld_sr[RET_STAGES-2:0], i_rd_en};
      hit_sr <= {hit_sr[RET_STAGES-2:0], i_rd_en & lk_hit};
    end
  end

  always_ff @(posedge i_clk) begin
    fwd_sr[0] <= lk_data;
    for (int i = 1; i < RET_STAGES; i++) fwd_sr[i] <= fwd_sr[i-1];
  end

  assign o_rd_vld  = vld_sr[RET_STAGES-1];
  assign o_rd_data = !o_rd_vld              ? '0 :
                     hit_sr[RET_STAGES-1]   ? fwd_sr[RET_STAGES-1] : i_ram_rdata;
  assign o_idle    = buf_empty & ~o_ram_en & ~en_d1;

endmodule
